// File: rtl/acc_pkg.sv
// acc_pkg
//   Shared definitions for the accelerator interface.
//   Provides the default channel count, the result-channel field widths,
//   the packed result struct (rd, data, error) and the width of the source
//   index used to tag results with the channel that produced them.
package acc_pkg;

    localparam int unsigned AccNumRsp  = 2;
    localparam int unsigned AccDataW   = 32;
    localparam int unsigned AccRdW     = 5;
    localparam int unsigned AccRspIdxW = (AccNumRsp > 1) ? $clog2(AccNumRsp) : 1;

    typedef struct packed {
        logic [AccRdW-1:0]   rd;
        logic [AccDataW-1:0] data;
        logic                error;
    } acc_rsp_t;

endpackage

// File: rtl/acc_rr_grant.sv
// acc_rr_grant
//   Purely combinational round-robin pick. The requester with the lowest
//   index at or after ptr_i, searching cyclically, wins.
//   Ports:
//     req_i  - request vector, one bit per requester
//     ptr_i  - priority pointer, index of the highest-priority requester
//     gnt_o  - one-hot winner (all zero when nothing requests)
//     idx_o  - encoded index of the winner (zero when nothing requests)
module acc_rr_grant #(
    parameter int unsigned NumReq   = 2,
    parameter int unsigned IdxWidth = (NumReq > 1) ? $clog2(NumReq) : 1
) (
    input  logic [NumReq-1:0]   req_i,
    input  logic [IdxWidth-1:0] ptr_i,
    output logic [NumReq-1:0]   gnt_o,
    output logic [IdxWidth-1:0] idx_o
);

    // Walk the requesters in priority order (ptr, ptr+1, ... wrapping) and
    // stop at the first one that is requesting. Both loops have constant
    // bounds, so every index into req_i/gnt_o is a constant after unrolling.
    always_comb begin
        int   pos;
        logic found;
        pos   = 0;
        found = 1'b0;
        gnt_o = '0;
        idx_o = '0;
        for (int k = 0; k < int'(NumReq); k++) begin
            pos = int'(ptr_i) + k;
            if (pos >= int'(NumReq)) begin
                pos = pos - int'(NumReq);
            end
            for (int i = 0; i < int'(NumReq); i++) begin
                if (!found && (i == pos) && req_i[i]) begin
                    found    = 1'b1;
                    gnt_o[i] = 1'b1;
                    idx_o    = IdxWidth'(i);
                end
            end
        end
    end

endmodule

// File: rtl/acc_rsp_arbiter.sv
// acc_rsp_arbiter
//   Shares the core's single accelerator result channel between NumRsp
//   response channels. A round-robin winner is captured into a one-entry
//   output register: one result per cycle, one cycle of latency.
//   Ports:
//     clk_i, rst_ni  - clock, asynchronous active-low reset
//     rsp_valid_i    - per-channel result valid
//     rsp_ready_o    - per-channel accept (one-hot or zero)
//     rsp_rd_i       - per-channel destination register, 5 bits each
//     rsp_data_i     - per-channel result data, DataWidth bits each
//     rsp_error_i    - per-channel error flag
//     p_valid_o      - result valid towards the core
//     p_ready_i      - core accepts the result
//     p_rd_o, p_data_o, p_error_o - registered result fields
//     p_idx_o        - index of the channel that produced the result
module acc_rsp_arbiter
    import acc_pkg::*;
#(
    parameter int unsigned NumRsp    = AccNumRsp,
    parameter int unsigned DataWidth = AccDataW,
    parameter int unsigned IdxWidth  = (NumRsp > 1) ? $clog2(NumRsp) : 1
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic [NumRsp-1:0]           rsp_valid_i,
    output logic [NumRsp-1:0]           rsp_ready_o,
    input  logic [NumRsp*AccRdW-1:0]    rsp_rd_i,
    input  logic [NumRsp*DataWidth-1:0] rsp_data_i,
    input  logic [NumRsp-1:0]           rsp_error_i,
    output logic                        p_valid_o,
    input  logic                        p_ready_i,
    output logic [AccRdW-1:0]           p_rd_o,
    output logic [DataWidth-1:0]        p_data_o,
    output logic                        p_error_o,
    output logic [IdxWidth-1:0]         p_idx_o
);

    logic                 load_en;
    logic [NumRsp-1:0]    gnt_raw;
    logic [NumRsp-1:0]    gnt;
    logic [IdxWidth-1:0]  gnt_idx;

    logic [AccRdW-1:0]    sel_rd;
    logic [DataWidth-1:0] sel_data;
    logic                 sel_error;

    logic                 valid_q, valid_d;
    logic [AccRdW-1:0]    rd_q, rd_d;
    logic [DataWidth-1:0] data_q, data_d;
    logic                 error_q, error_d;
    logic [IdxWidth-1:0]  idx_q, idx_d;
    logic [IdxWidth-1:0]  ptr_q, ptr_d;

    // The register can take a new entry when empty or drained this cycle.
    assign load_en = !valid_q || p_ready_i;

    acc_rr_grant #(
        .NumReq   (NumRsp),
        .IdxWidth (IdxWidth)
    ) u_grant (
        .req_i (rsp_valid_i),
        .ptr_i (ptr_q),
        .gnt_o (gnt_raw),
        .idx_o (gnt_idx)
    );

    // Gating with rst_ni keeps requesters from seeing an accept while the
    // register is held in reset (it would otherwise look empty).
    assign gnt         = gnt_raw & {NumRsp{load_en & rst_ni}};
    assign rsp_ready_o = gnt;

    // One-hot field mux driven by the raw winner.
    always_comb begin
        sel_rd    = '0;
        sel_data  = '0;
        sel_error = 1'b0;
        for (int i = 0; i < int'(NumRsp); i++) begin
            if (gnt_raw[i]) begin
                sel_rd    = rsp_rd_i[i*AccRdW +: AccRdW];
                sel_data  = rsp_data_i[i*DataWidth +: DataWidth];
                sel_error = rsp_error_i[i];
            end
        end
    end

    // Load on a grant, otherwise empty when drained. Data fields keep their
    // last value when the entry empties. The pointer moves past the winner.
    always_comb begin
        valid_d = valid_q;
        rd_d    = rd_q;
        data_d  = data_q;
        error_d = error_q;
        idx_d   = idx_q;
        ptr_d   = ptr_q;
        if (|gnt) begin
            valid_d = 1'b1;
            rd_d    = sel_rd;
            data_d  = sel_data;
            error_d = sel_error;
            idx_d   = gnt_idx;
            ptr_d   = (32'(gnt_idx) == NumRsp - 1) ? '0 : gnt_idx + IdxWidth'(1);
        end else if (p_ready_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= 1'b0;
            rd_q    <= '0;
            data_q  <= '0;
            error_q <= 1'b0;
            idx_q   <= '0;
            ptr_q   <= '0;
        end else begin
            valid_q <= valid_d;
            rd_q    <= rd_d;
            data_q  <= data_d;
            error_q <= error_d;
            idx_q   <= idx_d;
            ptr_q   <= ptr_d;
        end
    end

    assign p_valid_o = valid_q;
    assign p_rd_o    = rd_q;
    assign p_data_o  = data_q;
    assign p_error_o = error_q;
    assign p_idx_o   = idx_q;

endmodule
